ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, range 1..4, meaning cycles from RAM enable to valid ram_rdata.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port i_booted, input, 1 bit: 1 means the CPU owns RAM; 0 means the BIOS loader owns RAM.
REQ-007 SHALL have BIOS port inputs bios_req (1), bios_we (1), bios_be (4), bios_addr (ADDR_WIDTH) and bios_wdata (DATA_WIDTH).
REQ-008 SHALL have BIOS port outputs bios_gnt (1), bios_rvalid (1) and bios_rdata (DATA_WIDTH).
REQ-009 SHALL have instruction port inputs if_req (1) and if_addr (ADDR_WIDTH).
REQ-010 SHALL have instruction port outputs if_gnt (1), if_rvalid (1) and if_rdata (DATA_WIDTH); this port is read-only.
REQ-011 SHALL have data port inputs d_req, d_we, d_be, d_addr and d_wdata, with widths as for the BIOS port.
REQ-012 SHALL have data port outputs d_gnt, d_rvalid and d_rdata.
REQ-013 SHALL have RAM outputs ram_en (1), ram_we (1), ram_be (4), ram_addr (ADDR_WIDTH) and ram_wdata (DATA_WIDTH), plus RAM input ram_rdata (DATA_WIDTH).

Function
REQ-014 Handshake: a requester SHALL hold req and its command stable until gnt; gnt is combinational in the same cycle; a transfer occurs when req and gnt are both high.
REQ-015 SHALL grant at most one port per cycle; ram_en = OR of all grants; ram_we/be/addr/wdata SHALL be muxed from the granted port.
REQ-016 When no port is granted, ram_we/be/addr/wdata SHALL be 0.
REQ-017 On instruction-port grants, ram_we SHALL be 0 and ram_be SHALL be 4'b1111.
REQ-018 Mode FSM SHALL have states ST_BOOT, ST_DRAIN_TO_RUN, ST_RUN and ST_DRAIN_TO_BOOT.
REQ-019 In ST_BOOT: only bios_req is eligible; if_gnt = d_gnt = 0.
REQ-020 In ST_RUN: bios_gnt = 0; if_req and d_req are eligible.
REQ-021 In both DRAIN states, no grant SHALL be issued.
REQ-022 Transitions: ST_BOOT -> ST_DRAIN_TO_RUN when i_booted=1; ST_RUN -> ST_DRAIN_TO_BOOT when i_booted=0.
REQ-023 A DRAIN state SHALL exit to its target when the tag pipeline holds no read, checked in that same cycle.
REQ-024 An i_booted reversal during DRAIN SHALL return the FSM to the originating state after the pipeline empties.
REQ-025 Run-mode arbitration SHALL be round-robin between the instruction and data ports, using a last-granted flag updated on every grant.
REQ-026 If only one run-mode port requests, it SHALL be granted every cycle.
REQ-027 If both request, the port not granted most recently SHALL win.
REQ-028 Read return: each granted read SHALL push an owner tag into an RD_LATENCY-deep shift pipeline; writes push OWN_NONE.
REQ-029 On tag exit, the matching rvalid SHALL pulse for 1 cycle, and that port's rdata = ram_rdata.
REQ-030 Non-owner rdata SHALL be 0.
REQ-031 Read latency SHALL be exactly RD_LATENCY cycles from the grant cycle to rvalid.
REQ-032 Back-to-back reads SHALL be accepted every cycle, with full throughput and no bubbles.
REQ-033 Reads in flight at a mode change SHALL still return to their original owner.
REQ-034 Read data SHALL never be delivered to a port not holding the tag.

Reset
REQ-035 While rst_n=0 at posedge: FSM <= ST_BOOT, tag pipeline <= all OWN_NONE, last-granted <= instruction port (so data wins first contention).
REQ-036 During and after reset: all gnt, rvalid, rdata and ram_* outputs SHALL be 0, except grants enabled by the REQ-019 rules once rst_n=1.
REQ-037 Reset mid-read SHALL discard the in-flight read; no rvalid is issued for it.

Structure
REQ-038 Package ram_arb_pkg SHALL hold owner_t (OWN_NONE, OWN_BIOS, OWN_IF, OWN_D) and arb_state_t.
REQ-039 Sub-module arb_tag_pipe SHALL implement the parameterised owner-tag delay line, with ports clk, rst_n, i_tag and o_tag.
REQ-040 Total RTL SHALL be 120-400 lines.

Verification
REQ-041 Boot write: rst_n low 2 cycles, i_booted=0, bios write addr 0x10 data 0xDEADBEEF be 4'hF -> bios_gnt same cycle; ram_en=1, ram_we=1, ram_addr=0x10.
REQ-042 Boot read: bios read 0x10 with RAM model returning 0xDEADBEEF -> bios_rvalid exactly RD_LATENCY cycles later with bios_rdata=0xDEADBEEF; if_req held high -> if_gnt stays 0.
REQ-043 Mode drain: i_booted 0->1 the same cycle a BIOS read is granted (RD_LATENCY=2) -> FSM in ST_DRAIN_TO_RUN for 2 cycles, bios_rvalid delivered, then ST_RUN and if_gnt permitted.
REQ-044 Contention: if_req and d_req both held 6 cycles after reset -> grant order D, IF, D, IF, D, IF; each rvalid matches its own address.
REQ-045 Reset abort: reads granted, then rst_n=0 one cycle before rvalid -> no rvalid is seen; all outputs are 0 the next cycle.
REQ-046 Throughput: 8 consecutive d_req reads at addresses 0..7 -> 8 consecutive d_rvalid pulses, data in order.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: read-return owner tags and mode FSM states.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_BIOS,
      OWN_IF,
      OWN_D
   } owner_t;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_DRAIN_TO_RUN,
      ST_RUN,
      ST_DRAIN_TO_BOOT
   } arb_state_t;

   localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/ram_arbiter_tag_pipe.sv
// Owner-tag delay line: a tag pushed at a grant emerges DEPTH cycles later,
// aligned with the RAM's read data.
module arb_tag_pipe
   import ram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic   clk,
   input  logic   rst_n,
   input  owner_t i_tag,
   output owner_t o_tag
);

   owner_t stage [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage[i] <= OWN_NONE;
         end
      end else begin
         stage[0] <= i_tag;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign o_tag = stage[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: BIOS loader owns RAM before boot, then instruction
// and data ports share it round-robin; read data is routed back by owner tag.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_booted,
   input  logic                  bios_req,
   input  logic                  bios_we,
   input  logic [3:0]            bios_be,
   input  logic [ADDR_WIDTH-1:0] bios_addr,
   input  logic [DATA_WIDTH-1:0] bios_wdata,
   output logic                  bios_gnt,
   output logic                  bios_rvalid,
   output logic [DATA_WIDTH-1:0] bios_rdata,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [3:0]            d_be,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [3:0]            ram_be,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   arb_state_t state;
   logic       last_if;
   logic [2:0] pend;
   logic [2:0] pend_next;
   owner_t     push_tag;
   owner_t     out_tag;

   always_comb begin
      bios_gnt = 1'b0;
      if_gnt   = 1'b0;
      d_gnt    = 1'b0;
      if (rst_n) begin
         case (state)
            ST_BOOT: bios_gnt = bios_req;
            ST_RUN: begin
               if (if_req && d_req) begin
                  if_gnt = ~last_if;
                  d_gnt  = last_if;
               end else begin
                  if_gnt = if_req;
                  d_gnt  = d_req;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ram_we    = 1'b0;
      ram_be    = '0;
      ram_addr  = '0;
      ram_wdata = '0;
      push_tag  = OWN_NONE;
      if (bios_gnt) begin
         ram_we    = bios_we;
         ram_be    = bios_be;
         ram_addr  = bios_addr;
         ram_wdata = bios_wdata;
         if (!bios_we) push_tag = OWN_BIOS;
      end else if (if_gnt) begin
         ram_be   = BE_ALL;
         ram_addr = if_addr;
         push_tag = OWN_IF;
      end else if (d_gnt) begin
         ram_we    = d_we;
         ram_be    = d_be;
         ram_addr  = d_addr;
         ram_wdata = d_wdata;
         if (!d_we) push_tag = OWN_D;
      end
   end

   assign ram_en = bios_gnt | if_gnt | d_gnt;

   arb_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .i_tag (push_tag),
      .o_tag (out_tag)
   );

   always_comb begin
      bios_rvalid = rst_n && (out_tag == OWN_BIOS);
      if_rvalid   = rst_n && (out_tag == OWN_IF);
      d_rvalid    = rst_n && (out_tag == OWN_D);
      bios_rdata  = bios_rvalid ? ram_rdata : '0;
      if_rdata    = if_rvalid   ? ram_rdata : '0;
      d_rdata     = d_rvalid    ? ram_rdata : '0;
   end

   // pend counts reads in the tag pipe; a drain may end in the cycle the last one returns
   assign pend_next = pend + {2'b00, push_tag != OWN_NONE} - {2'b00, out_tag != OWN_NONE};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_BOOT;
         last_if <= 1'b1;
         pend    <= '0;
      end else begin
         pend <= pend_next;
         if (if_gnt)     last_if <= 1'b1;
         else if (d_gnt) last_if <= 1'b0;
         case (state)
            ST_BOOT: if (i_booted)  state <= ST_DRAIN_TO_RUN;
            ST_RUN:  if (!i_booted) state <= ST_DRAIN_TO_BOOT;
            // the drain target follows i_booted at exit, so a reversal goes home
            ST_DRAIN_TO_RUN, ST_DRAIN_TO_BOOT:
               if (pend_next == '0) state <= i_booted ? ST_RUN : ST_BOOT;
            default: state <= ST_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a RAM model and a queue-based ownership model.
module tb_ram_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_booted = 1'b0;
   logic        bios_req = 1'b0, bios_we = 1'b0;
   logic [3:0]  bios_be = '0;
   logic [31:0] bios_addr = '0, bios_wdata = '0;
   logic        bios_gnt, bios_rvalid;
   logic [31:0] bios_rdata;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [3:0]  d_be = '0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        ram_en, ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;

   int total = 0;
   int bad = 0;

   ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .i_booted(i_booted),
      .bios_req(bios_req), .bios_we(bios_we), .bios_be(bios_be),
      .bios_addr(bios_addr), .bios_wdata(bios_wdata),
      .bios_gnt(bios_gnt), .bios_rvalid(bios_rvalid), .bios_rdata(bios_rdata),
      .if_req(if_req), .if_addr(if_addr),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // RAM model driven purely by the DUT's ram_* outputs
   logic [31:0] ram_mem [256];
   logic [31:0] dline [LAT];
   initial for (int i = 0; i < 256; i++) ram_mem[i] = '0;
   initial for (int i = 0; i < LAT; i++) dline[i] = '0;
   assign ram_rdata = dline[LAT-1];

   always @(posedge clk) begin
      if (ram_en && ram_we) begin
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) ram_mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
      dline[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr[7:0]] : 32'h0;
      for (int i = 1; i < LAT; i++) dline[i] <= dline[i-1];
   end

   // Ownership model: who may use RAM, and a list of reads with their due cycles
   typedef struct {
      int          owner;
      int unsigned due;
      logic [31:0] data;
   } rd_t;
   rd_t         q[$];
   logic [31:0] mmem [256];
   initial for (int i = 0; i < 256; i++) mmem[i] = '0;
   int unsigned cyc = 0;
   bit m_run = 0, m_drain = 0, m_last_if = 1;
   logic        e_b, e_i, e_d, e_en, e_we;
   logic [3:0]  e_be;
   logic [31:0] e_addr, e_wdata, e_data;
   int          e_own;

   always @(negedge clk) begin
      e_b = 0; e_i = 0; e_d = 0;
      if (rst_n && !m_drain) begin
         if (!m_run) e_b = bios_req;
         else if (if_req && d_req) begin e_d = m_last_if; e_i = !m_last_if; end
         else begin e_i = if_req; e_d = d_req; end
      end
      e_en = e_b | e_i | e_d;
      e_we = e_b ? bios_we : (e_d ? d_we : 1'b0);
      e_be = e_b ? bios_be : (e_i ? 4'hF : (e_d ? d_be : 4'h0));
      e_addr = e_b ? bios_addr : (e_i ? if_addr : (e_d ? d_addr : 32'h0));
      e_wdata = e_b ? bios_wdata : (e_d ? d_wdata : 32'h0);
      e_own = 0; e_data = '0;
      if (rst_n && q.size() > 0 && q[0].due == cyc) begin e_own = q[0].owner; e_data = q[0].data; end

      chk("m_bios_gnt", bios_gnt, e_b);
      chk("m_if_gnt", if_gnt, e_i);
      chk("m_d_gnt", d_gnt, e_d);
      chk("m_ram_en", ram_en, e_en);
      chk("m_ram_we", ram_we, e_we);
      chk("m_ram_be", ram_be, e_be);
      chk("m_ram_addr", ram_addr, e_addr);
      chk("m_ram_wdata", ram_wdata, e_wdata);
      chk("m_bios_rvalid", bios_rvalid, e_own == 1);
      chk("m_if_rvalid", if_rvalid, e_own == 2);
      chk("m_d_rvalid", d_rvalid, e_own == 3);
      chk("m_bios_rdata", bios_rdata, e_own == 1 ? e_data : 32'h0);
      chk("m_if_rdata", if_rdata, e_own == 2 ? e_data : 32'h0);
      chk("m_d_rdata", d_rdata, e_own == 3 ? e_data : 32'h0);

      if (!rst_n) begin
         q.delete();
         m_run = 0; m_drain = 0; m_last_if = 1;
      end else begin
         while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
         if (e_en && e_we) begin
            for (int b = 0; b < 4; b++)
               if (e_be[b]) mmem[e_addr[7:0]][b*8 +: 8] = e_wdata[b*8 +: 8];
         end else if (e_en) begin
            q.push_back('{owner: e_b ? 1 : (e_i ? 2 : 3), due: cyc + LAT, data: mmem[e_addr[7:0]]});
         end
         if (e_i) m_last_if = 1;
         else if (e_d) m_last_if = 0;
         if (m_drain) begin
            if (q.size() == 0) begin m_drain = 0; m_run = i_booted; end
         end else if (i_booted != m_run) begin
            m_drain = 1;
         end
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   bit order [6];
   int wins;
   int nd, ni;
   logic g_d, g_i;

   initial begin
      repeat (2) begin
         @(negedge clk);
         chk("rst_ram_en", ram_en, 0);
         chk("rst_bios_gnt", bios_gnt, 0);
         step();
      end

      rst_n = 1; bios_req = 1; bios_we = 1; bios_be = 4'hF;
      bios_addr = 32'h10; bios_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("bw_gnt", bios_gnt, 1);
      chk("bw_ram_en", ram_en, 1);
      chk("bw_ram_we", ram_we, 1);
      chk("bw_ram_addr", ram_addr, 32'h10);
      step();

      bios_we = 0; if_req = 1; if_addr = 32'h20;
      @(negedge clk);
      chk("br_gnt", bios_gnt, 1);
      chk("br_if_gnt", if_gnt, 0);
      step();
      bios_req = 0;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         chk("br_rvalid", bios_rvalid, k == LAT);
         chk("br_if_gnt_hold", if_gnt, 0);
         if (k == LAT) chk("br_rdata", bios_rdata, 32'hDEADBEEF);
         step();
      end
      if_req = 0;

      bios_req = 1; bios_we = 1; bios_be = 4'hF;
      for (int i = 0; i < 8; i++) begin
         bios_addr = i; bios_wdata = 32'h100 + i;
         step();
      end
      bios_addr = 32'h20; bios_wdata = 32'h11223344; step();
      bios_be = 4'b0101; bios_wdata = 32'hAABBCCDD; step();
      bios_we = 0; bios_be = 4'hF;

      bios_addr = 32'h10; i_booted = 1;
      @(negedge clk);
      chk("dr_bios_gnt", bios_gnt, 1);
      step();
      bios_req = 0; if_req = 1; if_addr = 32'h20;
      @(negedge clk);
      chk("dr_if_gnt_1", if_gnt, 0);
      chk("dr_rvalid_1", bios_rvalid, 0);
      step();
      @(negedge clk);
      chk("dr_if_gnt_2", if_gnt, 0);
      chk("dr_rvalid_2", bios_rvalid, 1);
      chk("dr_rdata", bios_rdata, 32'hDEADBEEF);
      step();
      @(negedge clk);
      chk("run_if_gnt", if_gnt, 1);
      chk("run_if_be", ram_be, 4'hF);
      step();
      if_req = 0;
      repeat (LAT - 1) step();
      @(negedge clk);
      chk("run_if_rvalid", if_rvalid, 1);
      chk("run_if_rdata", if_rdata, 32'h11BB33DD);
      step();

      rst_n = 0;
      repeat (2) step();
      rst_n = 1;
      if_req = 1; d_req = 1; d_we = 0; d_be = 4'hF;
      nd = 0; ni = 0; d_addr = 0; if_addr = 1; wins = 0;
      for (int c = 0; c < 20 && wins < 6; c++) begin
         @(negedge clk);
         g_d = d_gnt; g_i = if_gnt;
         if (g_d || g_i) begin order[wins] = g_d; wins++; end
         step();
         if (g_d) begin nd++; d_addr = 2 * nd; end
         if (g_i) begin ni++; if_addr = 2 * ni + 1; end
      end
      if_req = 0; d_req = 0;
      chk("cont_count", wins, 6);
      for (int i = 0; i < 6; i++) chk("cont_order_is_d", order[i], (i % 2) == 0);
      repeat (LAT + 1) step();

      d_req = 1; d_we = 1; d_be = 4'b1100; d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("dw_gnt", d_gnt, 1);
      chk("dw_be", ram_be, 4'b1100);
      step();
      d_we = 0; d_be = 4'hF;
      for (int k = 0; k < 8 + LAT; k++) begin
         d_req = (k < 8); d_addr = k;
         @(negedge clk);
         if (k < 8) chk("tp_gnt", d_gnt, 1);
         chk("tp_rvalid", d_rvalid, k >= LAT);
         if (k >= LAT) chk("tp_rdata", d_rdata, 32'h100 + k - LAT);
         step();
      end
      d_req = 0;

      if_req = 1; if_addr = 32'h30;
      @(negedge clk);
      chk("rb_if_gnt", if_gnt, 1);
      step();
      if_req = 0;
      repeat (LAT - 1) step();
      @(negedge clk);
      chk("rb_if_rvalid", if_rvalid, 1);
      chk("rb_if_rdata", if_rdata, 32'hCAFE0000);
      step();

      d_req = 1; d_addr = 3; i_booted = 0; bios_req = 1; bios_addr = 32'h10;
      @(negedge clk);
      chk("rev_d_gnt", d_gnt, 1);
      chk("rev_bios_gnt", bios_gnt, 0);
      step();
      i_booted = 1;
      @(negedge clk);
      chk("rev_drain_d_gnt_1", d_gnt, 0);
      chk("rev_drain_bios_gnt", bios_gnt, 0);
      step();
      @(negedge clk);
      chk("rev_drain_d_gnt_2", d_gnt, 0);
      chk("rev_d_rvalid", d_rvalid, 1);
      chk("rev_d_rdata", d_rdata, 32'h103);
      step();
      @(negedge clk);
      chk("rev_back_run", d_gnt, 1);
      step();
      d_req = 0; bios_req = 0;
      repeat (LAT + 1) step();

      d_req = 1; d_addr = 5;
      @(negedge clk);
      chk("ab_gnt", d_gnt, 1);
      step();
      d_req = 0; rst_n = 0;
      @(negedge clk);
      chk("ab_rvalid_rst", d_rvalid, 0);
      step();
      rst_n = 1;
      @(negedge clk);
      chk("ab_rvalid", d_rvalid, 0);
      chk("ab_rdata", d_rdata, 0);
      chk("ab_ram_en", ram_en, 0);
      chk("ab_gnts", {bios_gnt, if_gnt, d_gnt}, 0);
      chk("ab_rvalids", {bios_rvalid, if_rvalid}, 0);
      step();
      repeat (LAT + 1) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
